// File: rtl/bmem_line_adapter.sv
// Initiator side of the burst-memory interface: round-robin arbitration between the
// I-cache and D-cache, turning each whole-line request into one 4-beat bmem burst.
module bmem_line_adapter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic              ic_read,
    output logic [LINE_W-1:0] ic_rdata,
    output logic              ic_resp,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              dc_resp,
    output logic [ADDR_W-1:0] bmem_address,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_resp
);
    localparam int unsigned BEATS      = LINE_W / BEAT_W;
    localparam int unsigned CNT_W      = $clog2(BEATS);
    localparam int unsigned LINE_BYTES = LINE_W / 8;
    localparam int unsigned HOLD_W     = LINE_W - BEAT_W;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CMD,
        S_RD_BEATS,
        S_WR_BEATS,
        S_WR_WAIT,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              last_grant_dc;
    logic              grant_dc;
    logic [HOLD_W-1:0] rd_hold;
    logic [HOLD_W-1:0] wr_hold;

    logic              ic_req_c;
    logic              dc_req_c;
    logic              pick_dc_c;
    logic              last_beat_c;
    logic [ADDR_W-1:0] req_addr_c;

    // Arbitration and next-state selection
    always_comb begin
        state_next  = state;
        ic_req_c    = ic_read;
        dc_req_c    = dc_read | dc_write;
        pick_dc_c   = dc_req_c && (!ic_req_c || !last_grant_dc);
        req_addr_c  = (pick_dc_c ? dc_addr : ic_addr) & LINE_MASK;
        last_beat_c = (cnt == CNT_W'(BEATS - 1));
        case (state)
            S_IDLE: begin
                if (pick_dc_c) begin
                    state_next = dc_write ? S_WR_BEATS : S_RD_CMD;
                end else if (ic_req_c) begin
                    state_next = S_RD_CMD;
                end
            end
            S_RD_CMD:   state_next = S_RD_BEATS;
            S_RD_BEATS: if (bmem_resp && last_beat_c) state_next = S_DONE;
            S_WR_BEATS: if (last_beat_c) state_next = S_WR_WAIT;
            S_WR_WAIT:  if (bmem_resp) state_next = S_DONE;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // State register, beat datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            last_grant_dc <= 1'b0;
            grant_dc      <= 1'b0;
            rd_hold       <= '0;
            wr_hold       <= '0;
            ic_rdata      <= '0;
            ic_resp       <= 1'b0;
            dc_rdata      <= '0;
            dc_resp       <= 1'b0;
            bmem_address  <= '0;
            bmem_read     <= 1'b0;
            bmem_write    <= 1'b0;
            bmem_wdata    <= '0;
        end else begin
            state     <= state_next;
            ic_resp   <= 1'b0;
            dc_resp   <= 1'b0;
            bmem_read <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (state_next != S_IDLE) begin
                        grant_dc      <= pick_dc_c;
                        last_grant_dc <= pick_dc_c;
                        cnt           <= '0;
                        bmem_address  <= req_addr_c;
                        if (state_next == S_WR_BEATS) begin
                            bmem_write <= 1'b1;
                            bmem_wdata <= dc_wdata[BEAT_W-1:0];
                            wr_hold    <= dc_wdata[LINE_W-1:BEAT_W];
                        end else begin
                            bmem_read <= 1'b1;
                        end
                    end
                end
                S_RD_CMD: begin
                    bmem_address <= '0;
                end
                S_RD_BEATS: begin
                    // Beats arrive low-order first; shift them down so beat 0 lands at [63:0]
                    if (bmem_resp) begin
                        cnt     <= cnt + CNT_W'(1);
                        rd_hold <= {bmem_rdata, rd_hold[HOLD_W-1:BEAT_W]};
                        if (last_beat_c) begin
                            if (grant_dc) begin
                                dc_resp  <= 1'b1;
                                dc_rdata <= {bmem_rdata, rd_hold};
                            end else begin
                                ic_resp  <= 1'b1;
                                ic_rdata <= {bmem_rdata, rd_hold};
                            end
                        end
                    end
                end
                S_WR_BEATS: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_beat_c) begin
                        bmem_write   <= 1'b0;
                        bmem_wdata   <= '0;
                        bmem_address <= '0;
                    end else begin
                        bmem_wdata <= wr_hold[BEAT_W-1:0];
                        wr_hold    <= wr_hold >> BEAT_W;
                    end
                end
                S_WR_WAIT: begin
                    if (bmem_resp) begin
                        dc_resp <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Bench for bmem_line_adapter: behavioural burst responder, round-robin order model
// and line scoreboard, with directed scenarios followed by randomized transactions.
module tb_bmem_line_adapter;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned BEAT_W = 64;
    localparam int unsigned BEATS  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_read;
    logic [LINE_W-1:0] ic_rdata;
    logic              ic_resp;
    logic [ADDR_W-1:0] dc_addr;
    logic              dc_read;
    logic              dc_write;
    logic [LINE_W-1:0] dc_wdata;
    logic [LINE_W-1:0] dc_rdata;
    logic              dc_resp;
    logic [ADDR_W-1:0] bmem_address;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_resp;

    bmem_line_adapter dut (
        .clk          (clk),
        .rst          (rst),
        .ic_addr      (ic_addr),
        .ic_read      (ic_read),
        .ic_rdata     (ic_rdata),
        .ic_resp      (ic_resp),
        .dc_addr      (dc_addr),
        .dc_read      (dc_read),
        .dc_write     (dc_write),
        .dc_wdata     (dc_wdata),
        .dc_rdata     (dc_rdata),
        .dc_resp      (dc_resp),
        .bmem_address (bmem_address),
        .bmem_read    (bmem_read),
        .bmem_write   (bmem_write),
        .bmem_wdata   (bmem_wdata),
        .bmem_rdata   (bmem_rdata),
        .bmem_resp    (bmem_resp)
    );

    int tests = 0;
    int fails = 0;

    // Responder and monitor state
    logic [63:0]  beats [BEATS];
    logic [255:0] rd_line;
    logic [63:0]  wr_q [$];
    logic [31:0]  last_addr;
    int  rd_left = 0, rd_idx = 0, gap_left = 0, gap_cfg = 0, stall_beat = 2;
    int  n_reads = 0, n_writes = 0;
    bit  wr_due = 0, in_wr = 0, spur_wr = 0, stray = 0, fixed_beats = 0;
    bit  prev_resp = 0, got_resp = 0, got_dc = 0;
    logic [255:0] got_data;

    // Reference model: last grant and the line each cache should currently see
    bit           m_last_d = 0;
    logic [255:0] m_ic_line = '0;
    logic [255:0] m_dc_line = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // One clock: observe at negedge, act as the cache side and as the burst memory
    task automatic step();
        bit r;
        @(negedge clk);
        r = ic_resp | dc_resp;
        if (bmem_read | bmem_write) chk("rw_exclusive", bmem_read & bmem_write, 1'b0);
        if (prev_resp) chk("resp_one_cycle", r, 1'b0);
        prev_resp = r;
        if (r) begin
            got_resp = 1;
            got_dc   = dc_resp;
            got_data = dc_resp ? dc_rdata : ic_rdata;
        end
        if (ic_resp) ic_read = 0;
        if (dc_resp) begin dc_read = 0; dc_write = 0; end

        bmem_resp  = 0;
        bmem_rdata = {$urandom, $urandom};
        if (wr_due) begin
            bmem_resp = 1;
            wr_due    = 0;
        end else if (rd_left > 0) begin
            if (rd_idx == stall_beat && gap_left > 0) gap_left--;
            else begin
                bmem_resp  = 1;
                bmem_rdata = beats[rd_idx];
                rd_idx++;
                rd_left--;
            end
        end
        if (bmem_read) begin
            n_reads++;
            last_addr = bmem_address;
            rd_idx    = 0;
            rd_left   = BEATS;
            gap_left  = gap_cfg;
            for (int i = 0; i < BEATS; i++) begin
                beats[i] = fixed_beats ? 64'h1111_1111_1111_1111 * 64'(i + 1) : {$urandom, $urandom};
                rd_line[i*64 +: 64] = beats[i];
            end
        end
        if (bmem_write) begin
            if (!in_wr) begin
                in_wr = 1;
                wr_q.delete();
                last_addr = bmem_address;
                n_writes++;
            end
            wr_q.push_back(bmem_wdata);
            if (spur_wr) bmem_resp = 1;
            if (wr_q.size() == BEATS) begin
                in_wr  = 0;
                wr_due = 1;
            end
        end
        if (stray) bmem_resp = 1;
    endtask

    task automatic wait_resp(output int lat);
        got_resp = 0;
        lat = 0;
        for (int c = 1; c <= 64; c++) begin
            step();
            if (got_resp) begin lat = c; break; end
        end
        chk("resp_seen", got_resp, 1'b1);
    endtask

    task automatic do_reset();
        rst = 0; ic_read = 0; dc_read = 0; dc_write = 0; stray = 0;
        rd_left = 0; wr_due = 0; in_wr = 0;
        step();
        step();
        rst = 1;
        m_last_d = 0; m_ic_line = '0; m_dc_line = '0;
    endtask

    // Present one or two requests together; expected service order from the round-robin rule
    task automatic do_txn(input bit i_en, input bit d_rd, input bit d_wr, input int gap,
                          input logic [31:0] ia, input logic [31:0] da,
                          input logic [255:0] wd, output int lat0);
        int n, lat, r0, w0;
        bit first_d, svc_d;
        logic [255:0] obs;
        step();
        ic_addr = ia; dc_addr = da; dc_wdata = wd; gap_cfg = gap;
        ic_read = i_en; dc_read = d_rd; dc_write = d_wr;
        n = int'(i_en) + int'(d_rd | d_wr);
        first_d = (d_rd | d_wr) && (!i_en || !m_last_d);
        lat0 = 0;
        for (int k = 0; k < n; k++) begin
            svc_d = (k == 0) ? first_d : !first_d;
            r0 = n_reads;
            w0 = n_writes;
            wait_resp(lat);
            if (k == 0) lat0 = lat;
            chk("resp_port", got_dc, svc_d);
            if (svc_d && d_wr) begin
                chk("wr_burst_count", n_writes - w0, 1);
                chk("wr_no_read", n_reads - r0, 0);
                chk("wr_beat_count", wr_q.size(), BEATS);
                obs = '0;
                for (int i = 0; i < wr_q.size() && i < BEATS; i++) obs[i*64 +: 64] = wr_q[i];
                chk("wr_beats", obs, wd);
                chk("wr_addr", last_addr, da & 32'hFFFF_FFE0);
                chk("wr_dc_rdata_hold", got_data, m_dc_line);
                chk("wr_ic_rdata_hold", ic_rdata, m_ic_line);
            end else begin
                chk("rd_burst_count", n_reads - r0, 1);
                chk("rd_no_write", n_writes - w0, 0);
                chk("rd_line", got_data, rd_line);
                chk("rd_addr", last_addr, (svc_d ? da : ia) & 32'hFFFF_FFE0);
                if (svc_d) begin
                    m_dc_line = rd_line;
                    chk("rd_ic_rdata_hold", ic_rdata, m_ic_line);
                end else begin
                    m_ic_line = rd_line;
                    chk("rd_dc_rdata_hold", dc_rdata, m_dc_line);
                end
            end
            m_last_d = svc_d;
        end
    endtask

    initial begin
        int lat;
        int kind;
        logic [255:0] wd;
        logic [255:0] exp_line;
        rst = 0; ic_addr = '0; ic_read = 0; dc_addr = '0; dc_read = 0; dc_write = 0;
        dc_wdata = '0; bmem_rdata = '0; bmem_resp = 0;
        do_reset();

        // Reset state
        chk("rst_ic_resp", ic_resp, 1'b0);
        chk("rst_dc_resp", dc_resp, 1'b0);
        chk("rst_bmem_cmd", {bmem_read, bmem_write}, 2'b00);
        chk("rst_bmem_address", bmem_address, 32'h0);
        chk("rst_bmem_wdata", bmem_wdata, 64'h0);
        chk("rst_rdata", {ic_rdata, dc_rdata}, 512'h0);

        // D read with known beats
        fixed_beats = 1;
        do_txn(0, 1, 0, 0, 32'h1000_0000, 32'h4000_0024, '0, lat);
        fixed_beats = 0;
        exp_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        chk("dread_line_const", got_data, exp_line);
        chk("dread_addr_const", last_addr, 32'h4000_0020);
        chk("dread_latency", lat, 6);

        // D writeback
        wd = rand256();
        do_txn(0, 0, 1, 0, 32'h0, 32'h4000_0040, wd, lat);
        chk("dwrite_latency", lat, 6);

        // Simultaneous requests after reset: D,I then D,I again
        do_reset();
        do_txn(1, 1, 0, 0, $urandom, $urandom, '0, lat);
        do_txn(1, 1, 0, 0, $urandom, $urandom, '0, lat);

        // Three idle cycles between beats 1 and 2
        stall_beat = 2;
        do_txn(0, 1, 0, 3, $urandom, $urandom, '0, lat);
        chk("stall_latency", lat, 9);

        // Reset in the middle of a read burst, after two beats accepted
        step();
        ic_addr = 32'h0000_1234; ic_read = 1; gap_cfg = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (rd_idx == 3) break;
        end
        chk("midrst_reached", rd_idx, 3);
        rst = 0; bmem_resp = 0; rd_left = 0; ic_read = 0;
        step();
        chk("midrst_resp", {ic_resp, dc_resp}, 2'b00);
        chk("midrst_cmd", {bmem_read, bmem_write}, 2'b00);
        chk("midrst_addr_wdata", {bmem_address, bmem_wdata}, 96'h0);
        chk("midrst_rdata", {ic_rdata, dc_rdata}, 512'h0);
        rst = 1;
        m_last_d = 0; m_ic_line = '0; m_dc_line = '0;
        stray = 1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("stray_no_resp", {ic_resp, dc_resp, bmem_read, bmem_write}, 4'b0000);
        end
        stray = 0;
        do_txn(1, 0, 0, 0, 32'h0000_8888, $urandom, '0, lat);
        chk("post_rst_latency", lat, 6);

        // Read and write together means write; memory responses during the beats are spurious
        spur_wr = 1;
        do_txn(0, 1, 1, 0, $urandom, $urandom, rand256(), lat);
        spur_wr = 0;
        chk("rdwr_latency", lat, 6);

        // Randomized mix
        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 5);
            stall_beat = $urandom_range(0, 3);
            case (kind)
                0: do_txn(1, 0, 0, $urandom_range(0, 2), $urandom, $urandom, rand256(), lat);
                1: do_txn(0, 1, 0, $urandom_range(0, 2), $urandom, $urandom, rand256(), lat);
                2: do_txn(0, 0, 1, $urandom_range(0, 2), $urandom, $urandom, rand256(), lat);
                3: do_txn(1, 1, 0, $urandom_range(0, 2), $urandom, $urandom, rand256(), lat);
                4: do_txn(1, 0, 1, $urandom_range(0, 2), $urandom, $urandom, rand256(), lat);
                default: do_txn(0, 1, 1, $urandom_range(0, 2), $urandom, $urandom, rand256(), lat);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
